// File: rtl/debug_pkg.sv
// rtl/debug_pkg.sv - shared label helpers and FSM state type for the debug read port
package debug_pkg;

    localparam int LABEL_CHARS = 7;
    localparam int LABEL_W     = LABEL_CHARS * 8;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_WAIT_RF = 2'd1,
        ST_RESP    = 2'd2
    } state_t;

    // Prefix character followed by the decimal value, right-justified, upper bytes zero.
    function automatic logic [LABEL_W-1:0] dec_label(input logic [7:0] prefix, input int unsigned val);
        logic [LABEL_W-1:0] r;
        int unsigned        v;
        int                 n;
        r = '0;
        v = val;
        n = 0;
        for (int i = 0; i < LABEL_CHARS - 1; i++) begin
            if (i == 0 || v != 0) begin
                r[i*8 +: 8] = 8'h30 + 8'(v % 10);
                v = v / 10;
                n = i + 1;
            end
        end
        r[n*8 +: 8] = prefix;
        return r;
    endfunction

    function automatic logic [LABEL_W-1:0] abi_label(input int unsigned index);
        case (index)
            0:  abi_label = LABEL_W'("zero");
            1:  abi_label = LABEL_W'("ra");
            2:  abi_label = LABEL_W'("sp");
            3:  abi_label = LABEL_W'("gp");
            4:  abi_label = LABEL_W'("tp");
            5:  abi_label = LABEL_W'("t0");
            6:  abi_label = LABEL_W'("t1");
            7:  abi_label = LABEL_W'("t2");
            8:  abi_label = LABEL_W'("s0");
            9:  abi_label = LABEL_W'("s1");
            10: abi_label = LABEL_W'("a0");
            11: abi_label = LABEL_W'("a1");
            12: abi_label = LABEL_W'("a2");
            13: abi_label = LABEL_W'("a3");
            14: abi_label = LABEL_W'("a4");
            15: abi_label = LABEL_W'("a5");
            16: abi_label = LABEL_W'("a6");
            17: abi_label = LABEL_W'("a7");
            18: abi_label = LABEL_W'("s2");
            19: abi_label = LABEL_W'("s3");
            20: abi_label = LABEL_W'("s4");
            21: abi_label = LABEL_W'("s5");
            22: abi_label = LABEL_W'("s6");
            23: abi_label = LABEL_W'("s7");
            24: abi_label = LABEL_W'("s8");
            25: abi_label = LABEL_W'("s9");
            26: abi_label = LABEL_W'("s10");
            27: abi_label = LABEL_W'("s11");
            28: abi_label = LABEL_W'("t3");
            29: abi_label = LABEL_W'("t4");
            30: abi_label = LABEL_W'("t5");
            31: abi_label = LABEL_W'("t6");
            default: abi_label = dec_label(8'h78, index);
        endcase
    endfunction

endpackage

// File: rtl/debug_label_rom.sv
// rtl/debug_label_rom.sv - combinational channel address to ASCII label lookup
module debug_label_rom
    import debug_pkg::*;
#(
    parameter int ADDR_W      = 7,
    parameter int NUM_REGS    = 32,
    parameter int NUM_PROBES  = 4,
    parameter int LABEL_CHARS = 7
) (
    input  logic [ADDR_W-1:0]        i_addr,
    output logic [LABEL_CHARS*8-1:0] o_label
);

    logic [LABEL_W-1:0] w_label;
    int                 w_addr;

    always_comb begin
        w_addr  = int'(i_addr);
        w_label = '0;
        if (w_addr == 0)
            w_label = LABEL_W'("pc");
        else if (w_addr < NUM_REGS)
            w_label = abi_label(unsigned'(w_addr));
        else if (w_addr < NUM_REGS + NUM_PROBES)
            w_label = dec_label(8'h70, unsigned'(w_addr - NUM_REGS));
        else
            w_label = LABEL_W'("?");
    end

    assign o_label = (LABEL_CHARS*8)'(w_label);

endmodule

// File: rtl/debug_probe_select.sv
// rtl/debug_probe_select.sv - one-at-a-time debug read port for PC, register file and probes
module debug_probe_select
    import debug_pkg::*;
#(
    parameter int DATA_W      = 32,
    parameter int NUM_REGS    = 32,
    parameter int NUM_PROBES  = 4,
    parameter int RF_LAT      = 1,
    parameter int ADDR_W      = 7,
    parameter int LABEL_CHARS = 7
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         req_valid,
    output logic                         req_ready,
    input  logic [ADDR_W-1:0]            req_addr,
    output logic [$clog2(NUM_REGS)-1:0]  rf_addr,
    input  logic [DATA_W-1:0]            rf_data,
    input  logic [DATA_W-1:0]            pc,
    input  logic [NUM_PROBES*DATA_W-1:0] probe_in,
    input  logic                         freeze,
    output logic                         resp_valid,
    input  logic                         resp_ready,
    output logic [ADDR_W-1:0]            resp_addr,
    output logic [DATA_W-1:0]            resp_data,
    output logic [LABEL_CHARS*8-1:0]     resp_label
);

    localparam int RFA_W = $clog2(NUM_REGS);

    state_t                         r_state;
    logic [2:0]                     r_cnt;
    logic [RFA_W-1:0]               r_rf_addr;
    logic [ADDR_W-1:0]              r_resp_addr;
    logic [DATA_W-1:0]              r_resp_data;
    logic [LABEL_CHARS*8-1:0]       r_resp_label;
    logic                           r_freeze_q;
    logic [DATA_W-1:0]              r_snap_pc;
    logic [NUM_PROBES*DATA_W-1:0]   r_snap_probe;

    logic [31:0]                    w_addr_ext;
    logic                           w_is_pc;
    logic                           w_is_reg;
    logic                           w_freeze_rise;
    logic                           w_use_snap;
    logic [DATA_W-1:0]              w_src_pc;
    logic [NUM_PROBES*DATA_W-1:0]   w_src_probes;
    logic [DATA_W-1:0]              w_imm_data;
    logic [LABEL_CHARS*8-1:0]       w_rom_label;

    debug_label_rom #(
        .ADDR_W      (ADDR_W),
        .NUM_REGS    (NUM_REGS),
        .NUM_PROBES  (NUM_PROBES),
        .LABEL_CHARS (LABEL_CHARS)
    ) u_label_rom (
        .i_addr  (req_addr),
        .o_label (w_rom_label)
    );

    assign w_addr_ext    = 32'(req_addr);
    assign w_is_pc       = (w_addr_ext == 32'd0);
    assign w_is_reg      = !w_is_pc && (w_addr_ext < 32'(NUM_REGS));
    assign w_freeze_rise = freeze && !r_freeze_q;
    // On the rising-edge cycle the snapshot being captured equals the live value.
    assign w_use_snap    = freeze && r_freeze_q;
    assign w_src_pc      = w_use_snap ? r_snap_pc : pc;
    assign w_src_probes  = w_use_snap ? r_snap_probe : probe_in;

    always_comb begin
        w_imm_data = '0;
        if (w_is_pc)
            w_imm_data = w_src_pc;
        for (int k = 0; k < NUM_PROBES; k++) begin
            if (w_addr_ext == 32'(NUM_REGS + k))
                w_imm_data = w_src_probes[k*DATA_W +: DATA_W];
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state      <= ST_IDLE;
            r_cnt        <= '0;
            r_rf_addr    <= '0;
            r_resp_addr  <= '0;
            r_resp_data  <= '0;
            r_resp_label <= '0;
            r_freeze_q   <= 1'b0;
            r_snap_pc    <= '0;
            r_snap_probe <= '0;
        end else begin
            r_freeze_q <= freeze;
            if (w_freeze_rise) begin
                r_snap_pc    <= pc;
                r_snap_probe <= probe_in;
            end
            case (r_state)
                ST_IDLE: begin
                    if (req_valid) begin
                        r_resp_addr  <= req_addr;
                        r_resp_label <= w_rom_label;
                        if (w_is_reg) begin
                            r_rf_addr <= req_addr[RFA_W-1:0];
                            r_cnt     <= 3'(RF_LAT);
                            r_state   <= ST_WAIT_RF;
                        end else begin
                            r_resp_data <= w_imm_data;
                            r_state     <= ST_RESP;
                        end
                    end
                end
                ST_WAIT_RF: begin
                    r_cnt <= r_cnt - 3'd1;
                    if (r_cnt == 3'd1) begin
                        r_resp_data <= rf_data;
                        r_state     <= ST_RESP;
                    end
                end
                ST_RESP: begin
                    if (resp_ready)
                        r_state <= ST_IDLE;
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign req_ready  = (r_state == ST_IDLE);
    assign resp_valid = (r_state == ST_RESP);
    assign rf_addr    = r_rf_addr;
    assign resp_addr  = r_resp_addr;
    assign resp_data  = r_resp_data;
    assign resp_label = r_resp_label;

endmodule

// File: tb/tb_debug_probe_select.sv
// tb/tb_debug_probe_select.sv - self-checking bench for debug_probe_select
module tb_debug_probe_select;

    localparam int RF_LAT = 2;

    logic         clk;
    logic         rst;
    logic         req_valid;
    logic         req_ready;
    logic [6:0]   req_addr;
    logic [4:0]   rf_addr;
    logic [31:0]  rf_data;
    logic [31:0]  pc;
    logic [127:0] probe_in;
    logic         freeze;
    logic         resp_valid;
    logic         resp_ready;
    logic [6:0]   resp_addr;
    logic [31:0]  resp_data;
    logic [55:0]  resp_label;

    int n_cmp = 0;
    int n_err = 0;

    logic [31:0]  rf_mem [32];
    logic [31:0]  m_snap_pc;
    logic [127:0] m_snap_probe;

    string abi_names [32] = '{"zero", "ra", "sp", "gp", "tp", "t0", "t1", "t2",
                              "s0", "s1", "a0", "a1", "a2", "a3", "a4", "a5",
                              "a6", "a7", "s2", "s3", "s4", "s5", "s6", "s7",
                              "s8", "s9", "s10", "s11", "t3", "t4", "t5", "t6"};

    typedef struct {
        logic [6:0] addr;
        string      label;
        int         lat;
    } vec_t;
    vec_t vecs [$];

    debug_probe_select #(
        .DATA_W(32), .NUM_REGS(32), .NUM_PROBES(4),
        .RF_LAT(RF_LAT), .ADDR_W(7), .LABEL_CHARS(7)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_addr   (req_addr),
        .rf_addr    (rf_addr),
        .rf_data    (rf_data),
        .pc         (pc),
        .probe_in   (probe_in),
        .freeze     (freeze),
        .resp_valid (resp_valid),
        .resp_ready (resp_ready),
        .resp_addr  (resp_addr),
        .resp_data  (resp_data),
        .resp_label (resp_label)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Register file: one registered read stage behind rf_addr.
    always @(posedge clk) rf_data <= rf_mem[rf_addr];

    initial begin
        #2000000;
        $display("FAIL timeout: simulation did not finish, got running required done");
        $fatal(1);
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h required %h", name, act, exp);
        end
    endtask

    function automatic logic [55:0] pack(input string s);
        logic [55:0] r;
        r = '0;
        for (int i = 0; i < s.len(); i++) r = {r[47:0], s[i]};
        return r;
    endfunction

    function automatic string ref_label(input logic [6:0] addr);
        int a;
        a = int'(addr);
        if (a == 0) return "pc";
        if (a < 32) return abi_names[a];
        if (a < 36) return $sformatf("p%0d", a - 32);
        return "?";
    endfunction

    function automatic logic [31:0] ref_data(input logic [6:0] addr);
        int a;
        a = int'(addr);
        if (a == 0) return freeze ? m_snap_pc : pc;
        if (a < 32) return rf_mem[a];
        if (a < 36) return freeze ? m_snap_probe[(a-32)*32 +: 32] : probe_in[(a-32)*32 +: 32];
        return 32'd0;
    endfunction

    function automatic int ref_lat(input logic [6:0] addr);
        return (addr != 0 && addr < 32) ? 1 + RF_LAT : 1;
    endfunction

    task automatic do_req(input logic [6:0] addr, input logic [31:0] exp_data,
                          input string exp_label, input int exp_lat, input int hold);
        int lat;
        check("req_ready_before", {63'd0, req_ready}, 64'd1);
        req_valid = 1'b1;
        req_addr  = addr;
        step();
        req_valid = 1'b0;
        req_addr  = $urandom_range(0, 127);
        lat = 1;
        while (!resp_valid && lat < 20) begin
            if (exp_lat > 1 && lat == 1) check("rf_addr", {59'd0, rf_addr}, {57'd0, addr});
            step();
            lat++;
        end
        check("latency", 64'(lat), 64'(exp_lat));
        check("resp_valid", {63'd0, resp_valid}, 64'd1);
        check("resp_data", {32'd0, resp_data}, {32'd0, exp_data});
        check("resp_label", {8'd0, resp_label}, {8'd0, pack(exp_label)});
        check("resp_addr", {57'd0, resp_addr}, {57'd0, addr});
        for (int i = 0; i < hold; i++) begin
            step();
            check("hold_data", {32'd0, resp_data}, {32'd0, exp_data});
        end
        resp_ready = 1'b1;
        step();
        resp_ready = 1'b0;
        check("after_handshake_valid", {63'd0, resp_valid}, 64'd0);
    endtask

    initial begin
        logic [6:0] a;
        rst = 1'b1; req_valid = 1'b0; req_addr = '0; freeze = 1'b0; resp_ready = 1'b0;
        pc = 32'h0000_1000;
        for (int i = 0; i < 32; i++) rf_mem[i] = $urandom;
        rf_mem[10] = 32'hDEAD_BEEF;
        probe_in = {$urandom, $urandom, $urandom, $urandom};
        m_snap_pc = '0; m_snap_probe = '0;
        step(); step();
        check("rst_req_ready", {63'd0, req_ready}, 64'd1);
        check("rst_resp_valid", {63'd0, resp_valid}, 64'd0);
        check("rst_resp_data", {32'd0, resp_data}, 64'd0);
        check("rst_resp_label", {8'd0, resp_label}, 64'd0);
        check("rst_resp_addr", {57'd0, resp_addr}, 64'd0);
        check("rst_rf_addr", {59'd0, rf_addr}, 64'd0);
        rst = 1'b0;
        step();

        vecs.push_back('{7'd0,   "pc",  1});
        vecs.push_back('{7'd10,  "a0",  3});
        vecs.push_back('{7'd27,  "s11", 3});
        vecs.push_back('{7'd1,   "ra",  3});
        vecs.push_back('{7'd2,   "sp",  3});
        vecs.push_back('{7'd8,   "s0",  3});
        vecs.push_back('{7'd17,  "a7",  3});
        vecs.push_back('{7'd18,  "s2",  3});
        vecs.push_back('{7'd31,  "t6",  3});
        vecs.push_back('{7'd32,  "p0",  1});
        vecs.push_back('{7'd35,  "p3",  1});
        vecs.push_back('{7'd36,  "?",   1});
        vecs.push_back('{7'h7F,  "?",   1});
        for (int i = 0; i < vecs.size(); i++)
            do_req(vecs[i].addr, ref_data(vecs[i].addr), vecs[i].label, vecs[i].lat, 0);
        do_req(7'd0, 32'h0000_1000, "pc", 1, 0);
        do_req(7'd10, 32'hDEAD_BEEF, "a0", 3, 0);
        do_req(7'h7F, 32'd0, "?", 1, 0);

        // Backpressure on probe 2 with a second request waiting.
        probe_in[95:64] = 32'hCAFE_0002;
        req_valid = 1'b1; req_addr = 7'd34;
        step();
        req_addr = 7'd0;
        for (int i = 0; i < 5; i++) begin
            check("bp_valid", {63'd0, resp_valid}, 64'd1);
            check("bp_req_ready", {63'd0, req_ready}, 64'd0);
            check("bp_data", {32'd0, resp_data}, 64'hCAFE_0002);
            check("bp_addr", {57'd0, resp_addr}, 64'd34);
            step();
        end
        resp_ready = 1'b1;
        step();
        resp_ready = 1'b0;
        check("bp_post_valid", {63'd0, resp_valid}, 64'd0);
        check("bp_post_ready", {63'd0, req_ready}, 64'd1);
        step();
        req_valid = 1'b0;
        check("bp_second_valid", {63'd0, resp_valid}, 64'd1);
        check("bp_second_addr", {57'd0, resp_addr}, 64'd0);
        check("bp_second_data", {32'd0, resp_data}, {32'd0, pc});
        resp_ready = 1'b1;
        step();
        resp_ready = 1'b0;

        // Freeze snapshot of pc.
        pc = 32'h40;
        freeze = 1'b1; m_snap_pc = pc; m_snap_probe = probe_in;
        step();
        pc = 32'h80;
        do_req(7'd0, 32'h40, "pc", 1, 0);
        freeze = 1'b0;
        step();
        do_req(7'd0, 32'h80, "pc", 1, 0);

        // Freeze edge in the accept cycle, then probe reads from the snapshot.
        pc = 32'h1234;
        probe_in[63:32] = 32'h1111_AAAA;
        freeze = 1'b1; m_snap_pc = pc; m_snap_probe = probe_in;
        do_req(7'd0, 32'h1234, "pc", 1, 0);
        pc = 32'h5678;
        probe_in[63:32] = 32'h2222_BBBB;
        do_req(7'd0, 32'h1234, "pc", 1, 0);
        do_req(7'd33, 32'h1111_AAAA, "p1", 1, 0);
        freeze = 1'b0;
        step();
        do_req(7'd33, 32'h2222_BBBB, "p1", 1, 0);

        // Reset while waiting on the register file.
        req_valid = 1'b1; req_addr = 7'd5;
        step();
        req_valid = 1'b0;
        check("wr_req_ready", {63'd0, req_ready}, 64'd0);
        step();
        rst = 1'b1;
        #1;
        check("wr_resp_valid", {63'd0, resp_valid}, 64'd0);
        check("wr_req_ready_rst", {63'd0, req_ready}, 64'd1);
        check("wr_rf_addr", {59'd0, rf_addr}, 64'd0);
        step(); step();
        check("wr_resp_valid_hold", {63'd0, resp_valid}, 64'd0);
        rst = 1'b0;
        step();
        check("wr_req_ready_rel", {63'd0, req_ready}, 64'd1);
        check("wr_no_resp", {63'd0, resp_valid}, 64'd0);
        do_req(7'd5, rf_mem[5], "t0", 3, 0);

        // Randomised traffic against the reference model.
        for (int it = 0; it < 60; it++) begin
            if (!freeze && $urandom_range(0, 3) == 0) begin
                freeze = 1'b1; m_snap_pc = pc; m_snap_probe = probe_in;
                step();
            end else if (freeze && $urandom_range(0, 3) == 0) begin
                freeze = 1'b0;
                step();
            end
            pc = $urandom;
            probe_in = {$urandom, $urandom, $urandom, $urandom};
            a = 7'($urandom_range(0, 127));
            if ($urandom_range(0, 1) == 0) a = 7'($urandom_range(0, 40));
            do_req(a, ref_data(a), ref_label(a), ref_lat(a), $urandom_range(0, 2));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
